// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported RAM to instruction fetch or data access,
// data first with a bounded streak, plus a sticky watchdog for a silent RAM.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramrdy,
    output logic        memerr
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, store_q, store_d;
    logic        wr_q, wr_d, memerr_q, memerr_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  timer_q, timer_d;
    logic        idle, acc, timed_out, done, d_req, d_gnt, i_gnt, i_done, d_done;
    logic [31:0] load;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

    assign idle      = state_q == IDLE;
    assign acc       = ~idle;
    assign d_req     = dREN | dWEN;
    assign d_gnt     = idle & d_req & (~iREN | (streak_q < STREAK_MAX));
    assign i_gnt     = idle & iREN & ~d_gnt;
    // A RAM that never answers is completed by the watchdog with a poison word.
    assign timed_out = acc & ~ramrdy & (timer_q == TMO_LAST);
    assign done      = acc & (ramrdy | timed_out);
    assign i_done    = (state_q == IACC) & done;
    assign d_done    = (state_q == DACC) & done;
    assign load      = ramrdy ? ramload : 32'hBAD1BAD1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = d_gnt ? DACC : i_gnt ? IACC : done ? IDLE : state_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            streak_q <= '0;
            timer_q  <= '0;
            memerr_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            memerr_q <= memerr_d;
        end
    end

    always_comb begin
        addr_d   = d_gnt ? {daddr[31:2], 2'b00} : i_gnt ? {iaddr[31:2], 2'b00} : addr_q;
        store_d  = (d_gnt & dWEN) ? dstore : store_q;
        wr_d     = d_gnt ? dWEN : i_gnt ? 1'b0 : wr_q;
        // The streak only counts data grants that actually made a fetch wait.
        streak_d = d_gnt ? (iREN ? ((streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1) : 4'd0)
                 : i_gnt ? 4'd0 : streak_q;
        timer_d  = idle ? 8'd0 : timer_q + 8'd1;
        memerr_d = memerr_q | timed_out;
    end

    always_comb begin
        ramREN   = (state_q == IACC) | ((state_q == DACC) & ~wr_q);
        ramWEN   = (state_q == DACC) & wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        iwait    = iREN & ~i_done;
        dwait    = d_req & ~d_done;
        iload    = i_done ? load : 32'h0;
        dload    = (d_done & ~wr_q) ? load : 32'h0;
        memerr   = memerr_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a latency-programmable RAM model,
// covering latency, priority, streak limit, latching, watchdog and async reset.
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        iwait, dwait, ramREN, ramWEN, ramrdy, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;

    int          n_tests = 0;
    int          n_fail = 0;
    int          lat = 1;
    logic        hang = 1'b0;
    int          acc_cnt;
    logic [31:0] ram_arr [1024];
    logic [31:0] exp_mem [1024];
    logic [31:0] iexp[$];
    logic [31:0] dexp[$];
    logic [7:0]  ord[$];

    mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramrdy(ramrdy), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    // RAM device: answers in the lat-th cycle of each strobe burst unless hung.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) acc_cnt <= 0;
        else       acc_cnt <= (ramREN | ramWEN) ? acc_cnt + 1 : 0;
    end
    assign ramrdy  = (ramREN | ramWEN) && !hang && (acc_cnt == lat - 1);
    assign ramload = ramREN ? ram_arr[ramaddr[11:2]] : 32'h0;
    always_ff @(posedge CLK) begin
        if (nRST && ramWEN && ramrdy) ram_arr[ramaddr[11:2]] <= ramstore;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            if (iREN && !iwait) begin
                ord.push_back("I");
                if (iexp.size() == 0) check("i_unexpected", 32'd1, 32'd0);
                else check("iload", iload, iexp.pop_front());
            end else if (iREN) begin
                check("iload_quiet", iload, 32'h0);
            end
            if ((dREN || dWEN) && !dwait) begin
                ord.push_back("D");
                if (dexp.size() == 0) check("d_unexpected", 32'd1, 32'd0);
                else if (dWEN) check("wstore", ramstore, dexp.pop_front());
                else check("dload", dload, dexp.pop_front());
            end else if (dREN) begin
                check("dload_quiet", dload, 32'h0);
            end
        end
    end

    task automatic i_stream(input int n, input logic [31:0] base, output int cyc);
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            iaddr = base + 32'(k * 4);
            iREN  = 1'b1;
            iexp.push_back(exp_mem[iaddr[11:2]]);
            cyc = 0;
            do begin @(negedge CLK); cyc++; end while (iwait && cyc < 64);
            if (iwait) check("i_bound", {31'd0, iwait}, 32'd0);
            @(posedge CLK); #1;
        end
        iREN = 1'b0;
    endtask

    task automatic d_stream(input int n, input logic [31:0] base, input logic wr,
                            input logic [31:0] data, input logic tmo, output int cyc);
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            daddr  = base + 32'(k * 4);
            dstore = data + 32'(k);
            dREN   = !wr;
            dWEN   = wr;
            if (wr) begin
                exp_mem[daddr[11:2]] = dstore;
                dexp.push_back(dstore);
            end else begin
                dexp.push_back(tmo ? 32'hBAD1BAD1 : exp_mem[daddr[11:2]]);
            end
            cyc = 0;
            do begin @(negedge CLK); cyc++; end while (dwait && cyc < 64);
            if (dwait) check("d_bound", {31'd0, dwait}, 32'd0);
            @(posedge CLK); #1;
        end
        dREN = 1'b0;
        dWEN = 1'b0;
    endtask

    initial begin
        int i_cyc, d_cyc;
        string exp_ord;
        for (int k = 0; k < 1024; k++) begin
            ram_arr[k] = 32'(k * 4) ^ 32'hA5A50000;
            exp_mem[k] = 32'(k * 4) ^ 32'hA5A50000;
        end
        ram_arr[16] = 32'h8C220004;
        exp_mem[16] = 32'h8C220004;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_memerr", {31'd0, memerr}, 32'd0);
        check("rst_iwait", {31'd0, iwait}, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Fetch with RAM latency 2: completes in cycle 2
        lat = 2;
        fork
            i_stream(1, 32'h40, i_cyc);
            begin
                @(negedge CLK);
                check("t1_idle_ren", {31'd0, ramREN}, 32'd0);
                repeat (2) begin
                    @(negedge CLK);
                    check("t1_ramREN", {31'd0, ramREN}, 32'd1);
                    check("t1_ramaddr", ramaddr, 32'h40);
                end
            end
        join
        check("t1_latency", 32'(i_cyc), 32'd3);

        // Simultaneous requests: data first, fetch waits for second completion
        lat = 1;
        fork
            i_stream(1, 32'h80, i_cyc);
            d_stream(1, 32'h200, 1'b0, 32'h0, 1'b0, d_cyc);
            begin
                repeat (2) @(negedge CLK);
                check("t2_ramaddr", ramaddr, 32'h200);
                check("t2_ramWEN", {31'd0, ramWEN}, 32'd0);
                check("t2_ramREN", {31'd0, ramREN}, 32'd1);
            end
        join
        check("t2_d_lat", 32'(d_cyc), 32'd2);
        check("t2_i_lat", 32'(i_cyc), 32'd4);

        // Streak limit: both held, four data grants then a forced fetch
        ord.delete();
        fork
            i_stream(2, 32'h300, i_cyc);
            d_stream(10, 32'h280, 1'b0, 32'h0, 1'b0, d_cyc);
        join
        exp_ord = "DDDDIDDDDIDD";
        check("t3_count", 32'(ord.size()), 32'(exp_ord.len()));
        for (int k = 0; k < exp_ord.len() && k < ord.size(); k++)
            check($sformatf("t3_order%0d", k), {24'd0, ord[k]}, {24'd0, exp_ord[k]});

        // Write with misaligned address; inputs change mid-access
        lat = 3;
        fork
            d_stream(1, 32'h103, 1'b1, 32'hDEADBEEF, 1'b0, d_cyc);
            begin
                @(negedge CLK);
                repeat (3) begin
                    @(negedge CLK);
                    check("t4_ramWEN", {31'd0, ramWEN}, 32'd1);
                    check("t4_ramaddr", ramaddr, 32'h100);
                    check("t4_ramstore", ramstore, 32'hDEADBEEF);
                    dstore = 32'h0;
                    daddr  = 32'h0;
                end
            end
        join
        check("t4_latency", 32'(d_cyc), 32'd4);
        lat = 1;
        d_stream(1, 32'h100, 1'b0, 32'h0, 1'b0, d_cyc);

        // Silent RAM: watchdog completes on the 16th access cycle
        hang = 1'b1;
        d_stream(1, 32'h500, 1'b0, 32'h0, 1'b1, d_cyc);
        check("t5_latency", 32'(d_cyc), 32'd17);
        check("t5_memerr", {31'd0, memerr}, 32'd1);
        hang = 1'b0;
        d_stream(1, 32'h104, 1'b0, 32'h0, 1'b0, d_cyc);
        i_stream(1, 32'h44, i_cyc);
        check("t5_memerr_sticky", {31'd0, memerr}, 32'd1);

        // Asynchronous reset in the middle of a write
        lat = 5;
        dWEN = 1'b1; daddr = 32'h104; dstore = 32'h12345678;
        repeat (2) @(negedge CLK);
        check("t6_pre_ramWEN", {31'd0, ramWEN}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("t6_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("t6_ramaddr", ramaddr, 32'h0);
        check("t6_ramstore", ramstore, 32'h0);
        check("t6_memerr", {31'd0, memerr}, 32'd0);
        check("t6_dwait", {31'd0, dwait}, 32'd1);
        dWEN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        lat = 1;
        i_stream(1, 32'h600, i_cyc);
        check("t6_i_lat", 32'(i_cyc), 32'd2);

        check("sb_empty", 32'(iexp.size() + dexp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported unified RAM between the instruction-fetch path (iREN) and the data path (dREN/dWEN) that the request unit drives.
- Registers a grant decision, holds address and store data stable for the whole RAM access, and returns the result with a one-cycle hit (wait low).
- Data has priority, with an anti-starvation limit for instruction fetch.
- A timeout watchdog flags a RAM that never answers.

Parameters:
- MAX_DSTREAK, 4, consecutive data grants allowed while iREN is pending before an instruction grant is forced (1..15).
- TIMEOUT, 16, cycles in an access state without ramrdy before forced completion (2..255).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous reset, active-low
- iREN  in  1  instruction read request, held until iwait low
- iaddr  in  32  instruction address
- iwait  out  1  1 = instruction request not complete this cycle
- iload  out  32  instruction word, valid when iREN & ~iwait
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  write data
- dwait  out  1  1 = data request not complete this cycle
- dload  out  32  read data, valid when dREN & ~dwait
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address, word-aligned
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid with ramrdy
- ramrdy  in  1  RAM completes current access this cycle
- memerr  out  1  sticky timeout flag

Behaviour:
- States: IDLE, IACC, DACC.
- IDLE:
  - RAM strobes 0.
  - Data grant if (dREN|dWEN) & (~iREN | streak<MAX_DSTREAK): go to DACC.
  - Otherwise, instruction grant if iREN: go to IACC.
  - On grant, latch addr[31:2] with [1:0]=0 into the address register; for a data write, also latch dstore.
  - On grant, latch the op: write if dWEN (dWEN wins when dREN & dWEN both set, no error); read otherwise.
  - Clear the timer.
- streak register (4 bits):
  - +1 on each data grant, saturating at MAX_DSTREAK.
  - Cleared on instruction grant.
  - Cleared on a data grant while iREN=0.
- IACC: ramREN=1, ramaddr=latched address.
  - On ramrdy: iload=ramload, iwait=0 this cycle, next IDLE.
- DACC: ramREN/ramWEN per latched op; ramaddr and ramstore from registers.
  - On ramrdy: dload=ramload (reads only), dwait=0 this cycle, next IDLE.
- Timer: counts cycles in IACC/DACC.
  - If it reaches TIMEOUT-1 without ramrdy, complete as if ramrdy: load value 32'hBAD1BAD1, memerr<=1.
  - memerr stays 1 until reset.
- Latency: request seen in IDLE at cycle 0, grant registered, RAM strobe from cycle 1. With RAM latency L (ramrdy in the L-th access cycle), completion is at cycle L. Minimum 2 cycles per access: IDLE is always revisited.
- Wait outputs (combinational):
  - iwait = iREN & ~(state==IACC & done).
  - dwait = (dREN|dWEN) & ~(state==DACC & done).
- iload/dload are 0 when not completing.
- Requester drops its request mid-access: the access runs to completion on RAM (writes are never aborted), result discarded, next IDLE.
- Address/data changes mid-access are ignored (latched values used).
- ramrdy outside IACC/DACC is ignored.
- Reset (any state, including mid-access): state IDLE, ramREN=ramWEN=0, ramaddr=0, ramstore=0, streak=0, timer=0, memerr=0. iwait/dwait then follow the requests; iload=dload=0.

Test Plan:
- iREN=1, iaddr=0x40; RAM answers ramrdy 2 cycles after ramREN rises, ramload=0x8C220004 -> ramaddr=0x40 from cycle 1, iwait=0 and iload=0x8C220004 in cycle 2 only.
- iREN and dREN asserted together, daddr=0x200 -> DACC first (ramaddr=0x200, ramWEN=0), then IACC; iwait stays 1 until the second completion.
- iREN held, dREN held with RAM latency 1, MAX_DSTREAK=4 -> grant order D,D,D,D,I,D...; streak reads 0 after the I grant.
- dWEN=1, daddr=0x103, dstore=0xDEADBEEF; dstore changed to 0 mid-access -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF throughout; dwait low for exactly one cycle.
- dREN with ramrdy never asserted, TIMEOUT=16 -> dwait=0 and dload=0xBAD1BAD1 on the 16th access cycle; memerr=1 and stays 1 over later good accesses.
- nRST pulsed low mid-DACC write -> ramWEN, ramaddr, memerr drop to 0 asynchronously; after release a new iREN is granted normally.
